// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic pipeline-stage register with valid/ready handshake,
// stall/flush controls, optional skid entry and performance counters.
module pipe_stage_elastic #(
    parameter int WIDTH = 32,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic             main_v, skid_v, main_v_n, skid_v_n, acc, take, live;
    logic [WIDTH-1:0] main_d, skid_d, main_d_n, skid_d_n;

    // With a skid entry, in_ready depends only on registered state plus en/clc.
    assign live      = rst_n & en & ~clc;
    assign in_ready  = live & ((SKID != 0) ? ~skid_v : (~main_v | out_ready));
    assign out_valid = main_v & live;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    always_comb begin
        main_v_n = main_v;
        main_d_n = main_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (clc) begin
            main_v_n = 1'b0;
            main_d_n = '0;
            skid_v_n = 1'b0;
            skid_d_n = '0;
        end else if (skid_v) begin
            if (take) begin
                main_d_n = skid_d;
                skid_v_n = 1'b0;
            end
        end else if (acc && (!main_v || take)) begin
            main_v_n = 1'b1;
            main_d_n = in_data;
        end else if (acc && SKID != 0) begin
            skid_v_n = 1'b1;
            skid_d_n = in_data;
        end else if (take) begin
            main_v_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            main_d    <= '0;
            skid_v    <= 1'b0;
            skid_d    <= '0;
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            main_v <= main_v_n;
            main_d <= main_d_n;
            skid_v <= skid_v_n;
            skid_d <= skid_d_n;
            if (out_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (take)
                xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed vectors with a queue scoreboard on the SKID=1 stage,
// plus a small reference model for a SKID=0 stage.
module tb_pipe_stage_elastic;
    logic        clk, rst_n, en, clc, in_valid, out_ready, in_ready, out_valid;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy, s_occ;
    logic [3:0]  stall_cnt, xfer_cnt;
    logic        s_in_valid, s_out_ready, s_in_ready, s_out_valid;
    logic [7:0]  s_in_data, s_out_data, md, d;
    logic [15:0] s_stall, s_xfer;
    logic        mv;
    int          vectors = 0, miscompares = 0, nt, ns;
    logic [31:0] exp_q[$];

    pipe_stage_elastic #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clc(clc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
    );

    pipe_stage_elastic #(.WIDTH(8), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clc(clc),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall), .xfer_cnt(s_xfer)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] dat, input logic r);
        in_valid  = v;
        in_data   = dat;
        out_ready = r;
    endtask

    // Pop before push so an entry offered this cycle is never matched against itself.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_data: unexpected output %0h with empty scoreboard", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(in_data);
        end
    end

    initial begin
        rst_n = 1; en = 1; clc = 0;
        drive(0, 0, 0);
        s_in_valid = 0; s_in_data = 0; s_out_ready = 0;
        #1 rst_n = 0;
        tick; tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_s_in_ready", s_in_ready, 0);
        rst_n = 1;
        #1 chk("release_in_ready", in_ready, 1);

        for (int i = 1; i <= 8; i++) begin
            drive(1, i, 1);
            tick;
            chk("stream_valid", out_valid, 1);
            chk("stream_latency", out_data, i);
        end
        drive(0, 0, 1);
        tick;
        chk("stream_drained", out_valid, 0);
        chk("hold_last_data", out_data, 8);
        chk("stream_xfer", xfer_cnt, 8);
        chk("stream_stall", stall_cnt, 0);

        drive(1, 'hA0, 1); tick;
        drive(1, 'hA1, 1); tick;
        drive(1, 'hA2, 0);
        #1 chk("bp_absorb_ready", in_ready, 1);
        tick;
        drive(1, 'hA3, 0);
        #1 chk("bp_full_ready", in_ready, 0);
        chk("bp_occupancy", occupancy, 2);
        chk("bp_main_data", out_data, 'hA1);
        repeat (3) tick;
        drive(1, 'hA3, 1);
        #1 chk("bp_release_ready", in_ready, 0);
        chk("bp_release_data", out_data, 'hA1);
        tick;
        chk("bp_skid_to_main", out_data, 'hA2);
        chk("bp_ready_again", in_ready, 1);
        tick;
        drive(0, 0, 1);
        tick;
        chk("bp_stall_cnt", stall_cnt, 4);
        chk("bp_xfer_cnt", xfer_cnt, 12);
        chk("bp_occupancy_end", occupancy, 0);

        drive(1, 'hB0, 0); tick;
        drive(1, 'hB1, 0); tick;
        en = 0;
        drive(1, 'hB2, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 0);
            chk("stall_occupancy", occupancy, 2);
            chk("stall_data", out_data, 'hB0);
            tick;
        end
        chk("stall_frozen_stall", stall_cnt, 5);
        chk("stall_frozen_xfer", xfer_cnt, 12);
        en = 1;
        tick; tick;
        drive(0, 0, 1);
        tick;
        chk("resume_xfer", xfer_cnt, 15);
        chk("resume_stall", stall_cnt, 5);

        drive(1, 'hC0, 0); tick;
        drive(1, 'hC1, 0); tick;
        chk("flush_pre_occ", occupancy, 2);
        en = 0; clc = 1;
        drive(1, 'hC2, 1);
        #1 chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        tick;
        clc = 0; en = 1;
        drive(0, 0, 0);
        exp_q.delete();
        #1 chk("flush_occupancy", occupancy, 0);
        chk("flush_out_valid_after", out_valid, 0);
        chk("flush_data_zero", out_data, 0);
        chk("flush_keeps_stall", stall_cnt, 6);
        chk("flush_keeps_xfer", xfer_cnt, 15);

        drive(1, 'hD0, 1); tick;
        clc = 1;
        drive(1, 'hD1, 1);
        #1 chk("flush_hs_ready", in_ready, 0);
        tick;
        clc = 0;
        drive(0, 0, 0);
        exp_q.delete();
        #1 chk("flush_hs_occupancy", occupancy, 0);
        chk("flush_hs_xfer", xfer_cnt, 15);

        drive(1, 'hE0, 1); tick;
        drive(0, 0, 1); tick;
        chk("xfer_wrap", xfer_cnt, 0);

        drive(1, 'hF0, 0); tick;
        drive(0, 0, 0);
        repeat (20) tick;
        chk("stall_saturate", stall_cnt, 15);

        drive(1, 'hF1, 0);
        #2 rst_n = 0;
        #1 chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_occupancy", occupancy, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_stall", stall_cnt, 0);
        chk("async_xfer", xfer_cnt, 0);
        exp_q.delete();
        drive(0, 0, 0);
        tick;
        rst_n = 1;
        #1 chk("rerelease_in_ready", in_ready, 1);

        // SKID=0 reference: ready = ~held | out_ready, a held entry is replaced on take.
        mv = 0; md = 0; d = 8'h10; nt = 0; ns = 0;
        s_in_valid = 1;
        for (int c = 0; c < 8; c++) begin
            s_out_ready = c[0];
            s_in_data = d;
            #1 chk("s0_in_ready", s_in_ready, !mv || s_out_ready);
            chk("s0_occupancy", s_occ, mv);
            chk("s0_out_valid", s_out_valid, mv);
            if (mv)
                chk("s0_out_data", s_out_data, md);
            if (mv && s_out_ready) nt++;
            if (mv && !s_out_ready) ns++;
            tick;
            if (!mv || s_out_ready) begin
                mv = 1;
                md = d;
                d++;
            end
        end
        chk("s0_xfer_cnt", s_xfer, nt);
        chk("s0_stall_cnt", s_stall, ns);
        s_in_valid = 0;
        s_out_ready = 1;
        tick;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register for the 5-stage RV32 pipeline. It replaces the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Each instance carries an opaque WIDTH-bit payload (result, rd, control bits, PC, instruction) with a valid/ready handshake, stall (`en`) and flush (`clc`) controls, an optional skid entry for a registered upstream ready, and occupancy and back-pressure counters for performance debug.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- SKID, 1, 1 = two-entry stage with registered `in_ready`; 0 = single-entry stage with combinational `in_ready`
- CNT_W, 16, width of the statistics counters
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset; asynchronous, active-low
- en  input  1  stage enable; 0 = freeze (no handshake, no state change except flush)
- clc  input  1  synchronous flush; drops all held entries
- in_valid  input  1  upstream entry offered
- in_ready  output  1  stage accepts an entry this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload of the oldest entry
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)
- stall_cnt  output  CNT_W  saturating count of back-pressured cycles
- xfer_cnt  output  CNT_W  wrapping count of output transfers

## Operation
- Storage: main entry (main_v, main_d) drives the outputs. Skid entry (skid_v, skid_d) exists only when SKID=1.
- Transfers: acc = in_valid & in_ready; take = out_valid & out_ready.
- Gating: out_valid = main_v & en & ~clc. out_data = main_d.
- SKID=1: in_ready = en & ~clc & ~skid_v. It is combinational only through en and clc.
- SKID=0: in_ready = en & ~clc & (~main_v | out_ready).
- States, SKID=1:
  - EMPTY (occupancy 0): acc → ONE, main_d ← in_data.
  - ONE (occupancy 1):
    - acc & take → ONE, main_d ← in_data.
    - acc & ~take → FULL, skid_d ← in_data.
    - ~acc & take → EMPTY.
    - otherwise hold.
  - FULL (occupancy 2): take → ONE, main_d ← skid_d, skid_v ← 0. in_ready = 0, so acc cannot occur.
- States, SKID=0: EMPTY/ONE only. acc & take in ONE replaces main_d.
- Flush: clc=1 at an edge clears main_v and skid_v and zeroes main_d and skid_d.
  - Flush dominates en; it acts even when en=0.
  - No handshake occurs in a flush cycle.
- Stall: en=0 & clc=0 holds all entries, data and counters unchanged.
- main_d holds its last value after a pop to EMPTY. It is zero only after reset or flush.
- stall_cnt: increments when main_v & en & ~clc & ~out_ready. It saturates at all-ones.
- xfer_cnt: increments on each take and wraps modulo 2^CNT_W.
- Counters are cleared only by reset. Flush does not clear them.
- Payload is never modified; width is preserved bit-for-bit.

## Timing
- Reset (rst_n=0, asynchronous): main_v=skid_v=0, main_d=skid_d=0, stall_cnt=xfer_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, occupancy=0, in_ready=0.
  - in_ready is forced 0 while rst_n=0.
- Release: rst_n is deasserted synchronously to clk by the top level. in_ready rises in the same cycle rst_n goes high, provided en=1 and clc=0.
- Latency: in_data accepted at edge N appears on out_data and out_valid after edge N (1 cycle). With SKID=1 and back-pressure, an entry waits in skid until main drains.
- Throughput: one transfer per cycle when out_ready=1 continuously.
- SKID=1: after out_ready drops, exactly one further entry is absorbed, then in_ready=0 from the next cycle.
- Simultaneous flush and handshake: clc=1 suppresses both acc and take. Held and offered entries are lost, and xfer_cnt does not increment.
- Reset mid-operation clears entries and counters immediately, without waiting for an edge.
- Counter saturation: stall_cnt at 2^CNT_W−1 stays there. xfer_cnt wraps to 0.

## Test plan
- Streaming: WIDTH=32, SKID=1. Drive in_data=1..8 on 8 consecutive cycles with out_ready=1 → out_data 1..8 one cycle later, in order. xfer_cnt=8, stall_cnt=0.
- Back-pressure: SKID=1, out_ready=0 from cycle 3 while streaming 0xA0,0xA1,0xA2… → occupancy reaches 2, in_ready=0. Release → out_data 0xA1, then 0xA2 with no loss. stall_cnt equals the stalled cycles.
- Flush: SKID=1, FULL state, pulse clc=1 with en=0 → next cycle occupancy=0, out_valid=0, out_data=0. Counters unchanged.
- Stall: en=0 for 3 cycles with in_valid=1 and out_ready=1 → in_ready=0, out_valid=0. Entries, out_data and counters are frozen. Resuming en=1 continues the original order.
- SKID=0: single entry, out_ready toggles every cycle → in_ready follows ~main_v | out_ready combinationally. Occupancy never exceeds 1.
- Reset and saturation: CNT_W=4, hold back-pressure for 20 cycles → stall_cnt=15. Assert rst_n=0 mid-stream → all outputs 0 asynchronously, before the next edge.
